vram_loader: RTL and testbench

- Write-side counterpart of the sprite draw path: receives a pixel byte stream over a valid/ready handshake.
- Writes the stream into a square entity sprite RAM (ENTITYSIZE x ENTITYSIZE) in raster order, addr = row*ENTITYSIZE + col.
- This matches the draw side's read mapping, so a loaded sprite displays unchanged.
- Writes are gated by a blanking qualifier so the draw path never sees a half-updated sprite mid-frame.

---
 rtl/vram_loader_pkg.sv | 13 +
 rtl/raster_counter.sv | 56 +++++
 rtl/vram_loader.sv | 114 +++++++++++
 tb/tb_vram_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vram_loader_pkg.sv
// Shared defaults and FSM encoding for the sprite VRAM loader and its raster counter.
package vram_loader_pkg;

  localparam int ENTITYSIZE_DEF = 32;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/raster_counter.sv
// Two-dimensional col/row counter walking a SIZE x SIZE tile in raster order.
module raster_counter
  import vram_loader_pkg::*;
#(
  parameter int SIZE = ENTITYSIZE_DEF,
  localparam int CW = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_enable,
  output logic [CW-1:0] o_col,
  output logic [CW-1:0] o_row,
  output logic          o_last
);

  logic [CW-1:0] col_reg, col_next;
  logic [CW-1:0] row_reg, row_next;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_reg == CW'(SIZE - 1));
  assign row_end = (row_reg == CW'(SIZE - 1));

  // Clear wins over enable; after the last pixel both axes wrap back to the origin.
  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (i_clear) begin
      col_next = '0;
      row_next = '0;
    end else if (i_enable) begin
      if (col_end) begin
        col_next = '0;
        row_next = row_end ? '0 : row_reg + CW'(1);
      end else begin
        col_next = col_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  assign o_col  = col_reg;
  assign o_row  = row_reg;
  assign o_last = col_end && row_end;

endmodule

// File: rtl/vram_loader.sv
// Streams a pixel byte stream into the sprite RAM in raster order, only while blanking.
module vram_loader
  import vram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ENTITYSIZE = ENTITYSIZE_DEF
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_blank,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_mem_write,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CW = $clog2(ENTITYSIZE);

  state_t state_reg, state_next;

  logic                  ready;
  logic                  transfer;
  logic                  cnt_clear;
  logic [CW-1:0]         col;
  logic [CW-1:0]         row;
  logic                  last_pixel;
  logic [ADDR_WIDTH-1:0] pix_addr;

  logic                  mem_write_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [DATA_WIDTH-1:0] mem_data_reg;

  raster_counter #(
    .SIZE (ENTITYSIZE)
  ) u_raster_counter (
    .clk      (clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (cnt_clear),
    .i_enable (transfer),
    .o_col    (col),
    .o_row    (row),
    .o_last   (last_pixel)
  );

  // Edge length is a power of two, so row*ENTITYSIZE + col is just {row, col}.
  always_comb begin
    pix_addr = '0;
    pix_addr[2*CW-1:0] = {row, col};
  end

  assign ready    = (state_reg == LOAD) && i_blank && !i_abort;
  assign transfer = i_valid && ready;

  always_comb begin
    state_next = state_reg;
    cnt_clear  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          state_next = LOAD;
          cnt_clear  = 1'b1;
        end
      end
      LOAD: begin
        if (i_abort) begin
          state_next = IDLE;
          cnt_clear  = 1'b1;
        end else if (transfer && last_pixel) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Address and data only move on a transfer so they hold between writes.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_data_reg  <= '0;
    end else begin
      mem_write_reg <= transfer;
      if (transfer) begin
        mem_addr_reg <= pix_addr;
        mem_data_reg <= i_data;
      end
    end
  end

  assign o_ready     = ready;
  assign o_mem_write = mem_write_reg;
  assign o_mem_addr  = mem_addr_reg;
  assign o_mem_data  = mem_data_reg;
  assign o_busy      = (state_reg == LOAD);
  assign o_done      = (state_reg == DONE);

endmodule

// File: tb/tb_vram_loader.sv
// Directed bench for vram_loader with a 4x4 sprite; expected writes are queued per transfer.
module tb_vram_loader;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int ES = 4;
  localparam int NPIX = ES * ES;

  logic          clk;
  logic          i_rst_n;
  logic          i_start;
  logic          i_abort;
  logic          i_blank;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_ready;
  logic          o_mem_write;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic          o_busy;
  logic          o_done;

  vram_loader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ENTITYSIZE (ES)
  ) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_blank     (i_blank),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_mem_write (o_mem_write),
    .o_mem_addr  (o_mem_addr),
    .o_mem_data  (o_mem_data),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   mstate = 0;   // 0 idle, 1 load, 2 done
  int   midx = 0;     // next pixel index of the model

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare the registered write port against the write queued last cycle.
  task automatic check_outputs();
    exp_t e;
    check("mem_write", o_mem_write, sb.size() != 0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (o_mem_write) begin
        check("mem_addr", o_mem_addr, e.addr);
        check("mem_data", o_mem_data, e.data);
        check("done_pulse", o_done, e.done);
        $display("[TB] write addr=%0d data=%02h done=%0b", o_mem_addr, o_mem_data, o_done);
      end
    end else begin
      check("done_without_write", o_done, 1'b0);
    end
  endtask

  task automatic step(input logic st, input logic ab, input logic bl, input logic va,
                      input logic [DW-1:0] d, output logic xfer);
    logic exp_ready;
    i_start = st;
    i_abort = ab;
    i_blank = bl;
    i_valid = va;
    i_data  = d;
    #2;
    check_outputs();
    exp_ready = (mstate == 1) && bl && !ab;
    check("ready", o_ready, exp_ready);
    check("busy", o_busy, mstate == 1);
    xfer = va && exp_ready;
    if (xfer) sb.push_back('{addr: AW'(midx), data: d, done: (midx == NPIX - 1)});
    case (mstate)
      0: if (st) begin mstate = 1; midx = 0; end
      1: begin
        if (ab) begin
          mstate = 0;
          midx = 0;
        end else if (xfer) begin
          if (midx == NPIX - 1) begin
            mstate = 2;
            midx = 0;
          end else begin
            midx++;
          end
        end
      end
      default: mstate = 0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic va, input logic [DW-1:0] d);
    i_start = 1'b0;
    i_abort = 1'b0;
    i_blank = 1'b1;
    i_valid = va;
    i_data  = d;
    #2;
    check_outputs();
    i_rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ready", o_ready, 1'b0);
    check("rst_write", o_mem_write, 1'b0);
    check("rst_addr", o_mem_addr, '0);
    check("rst_data", o_mem_data, '0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    $display("[TB] reset applied");
    i_rst_n = 1'b1;
    mstate = 0;
    midx = 0;
    sb.delete();
  endtask

  // mode 0: plain, 1: blank stall after 5 transfers for 7 cycles, 2: valid toggling
  task automatic run_load(input int mode);
    logic x;
    int   k = 0;
    int   c = 0;
    int   stall = 0;
    bit   stalled = 0;
    logic bl;
    logic va;
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, x);
    while (mstate != 0 && c < 200) begin
      if (mode == 1 && k == 5 && !stalled) begin
        stall = 7;
        stalled = 1;
      end
      bl = (stall == 0);
      if (stall > 0) stall--;
      va = (mode == 2) ? (c % 2 == 0) : 1'b1;
      step(1'b0, 1'b0, bl, va, 8'(8'h10 + k), x);
      if (x) k++;
      c++;
    end
    check("load_timeout", c < 200, 1'b1);
    check("load_count", k, NPIX);
  endtask

  initial begin
    logic x;
    int   k;
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_blank = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 8'h00);

    // 1. full load
    run_load(0);
    check("idle_after_load", o_busy, 1'b0);

    // 2. blanking stall
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, x);
    run_load(1);

    // 3. source backpressure
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, x);
    run_load(2);

    // 4. abort with a simultaneous valid byte after 6 transfers; abort in idle is a no-op
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hEE, x);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, x);
    k = 0;
    for (int c = 0; c < 50 && k < 6; c++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'(8'h10 + k), x);
      if (x) k++;
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'(8'h10 + k), x);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, x);
    check("abort_idle", o_busy, 1'b0);
    run_load(0);

    // 5. start ignored at 3rd transfer, reset at 9th
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, x);
    k = 0;
    for (int c = 0; c < 50 && k < 8; c++) begin
      step(k == 2, 1'b0, 1'b1, 1'b1, 8'(8'h30 + k), x);
      if (x) k++;
    end
    do_reset(1'b1, 8'(8'h30 + k));
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h55, x);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, x);

    // 6. back-to-back loads, start two cycles after o_done
    run_load(0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, x);
    run_load(0);

    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, x);
    check("queue_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
